hid_cmd_sequencer: RTL and testbench
====================================

Name: hid_cmd_sequencer

Overview:
Sits between the UART receive line buffer and the paint framebuffer/cursor logic.
- Latches each completed text line and decodes a one-letter command with hex fields.
- Drives pixel-write transactions to the framebuffer, including a full-screen clear.
- Updates the cursor, then returns a status byte to the UART transmitter.
- Owns the framebuffer write port on behalf of the HID path and sequences every multi-cycle operation.

Parameters:
- WIDTH, 64, screen width in pixels
- HEIGHT, 64, screen height in pixels
- XW, 6, x coordinate width, clog2(WIDTH)
- YW, 6, y coordinate width, clog2(HEIGHT)
- CW, 4, colour index width, must be ≤4 (one hex digit)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- line_ready  in  1  one-cycle pulse, line valid
- line  in  128  ASCII line; byte k at line[8k+:8]; byte 0 = opcode
- busy  out  1  high whenever state ≠ IDLE
- px_valid  out  1  pixel write request
- px_ready  in  1  framebuffer accepts when px_valid&&px_ready
- px_x  out  XW  write x
- px_y  out  YW  write y
- px_color  out  CW  write colour
- cur_x  out  XW  cursor x
- cur_y  out  YW  cursor y
- tx_valid  out  1  status byte valid
- tx_ready  in  1  UART TX accepts when tx_valid&&tx_ready
- tx_data  out  8  status byte
- drop_cnt  out  8  lines dropped while busy, saturating

Behaviour:
- Reset (async, rst=1): state IDLE; busy, px_valid, tx_valid = 0; px_x/px_y/px_color/cur_x/cur_y/tx_data/drop_cnt = 0. Reset mid-transaction aborts it immediately; no completion byte is sent afterwards.
- States:
  - IDLE: on line_ready, latch line into an internal register → DECODE.
  - DECODE: one cycle; decode per the opcode table below; set status byte; → PIXEL / CLEAR / RESP.
  - PIXEL: hold px_* stable with px_valid=1 until px_ready; → RESP on the handshake cycle.
  - CLEAR: scan counter x fastest, then y, from (0,0) to (WIDTH-1,HEIGHT-1). Advance only on handshake. px_valid stays high continuously. After the last pixel's handshake → RESP.
  - RESP: tx_valid=1, tx_data held stable until tx_ready; → IDLE on the handshake cycle.
- Opcode table (hex digits accept 0-9, A-F, a-f; XX/YY are 2 hex digits, C is 1 hex digit):
  - "PXXYYC": write pixel (XX,YY) with colour C; cursor is unchanged.
  - "CC": clear the whole screen to colour C.
  - "MXXYY": set cursor.
  - "D C": draw at cursor; byte 1 is ignored, byte 2 is the colour.
- Errors → status 'E' (0x45), RESP directly, no pixel/cursor side effects:
  - unknown opcode;
  - any invalid hex digit;
  - coordinate ≥ WIDTH/HEIGHT;
  - colour ≥ 2^CW.
- Success status 'K' (0x4B).
- Latency: line_ready at cycle n → px_valid first high at n+2 for P/D/C. For M, tx_valid is high at n+2; cursor updates at n+2.
- Lines are accepted only in IDLE. line_ready in any other state (including the IDLE→DECODE transition cycle is excluded, since that is IDLE) → line discarded, drop_cnt += 1, saturating at 255.
- The latched line is unaffected by new line_ready while busy.
- Bytes beyond an opcode's fields are ignored.

Optional Feature:
- Macro HID_CMD_ECHO_EN.
- Defined: RESP sends two bytes in order, status then the latched opcode byte. Each byte uses its own tx handshake; IDLE is entered after the second handshake.
- Undefined: only the status byte is sent; no opcode register logic is built.

Test Plan:
- Line "P0A1F7" with px_ready=1 → single px write (10,31,7) at n+2; then tx_data=0x4B; cur unchanged; busy low after TX handshake.
- Line "C3" with px_ready toggling 1/0 → exactly 4096 handshakes covering all (x,y) in order with colour 3; then 'K'.
- Line "M0504" then "D 9" → cur=(5,4); then px write (5,4,9); two 'K' bytes.
- Lines "P4000A1", "PZZ001", "Q" → no px_valid; each returns 0x45.
- Mid-clear: inject 3 line_ready pulses → drop_cnt=3 and the clear completes. Assert rst mid-clear → all outputs 0 immediately; no 'K' sent.
- HID_CMD_ECHO_EN defined, "M0102" with tx_ready held low 5 cycles → tx_data stable at 0x4B, then 0x4D; busy clears after the second handshake.

Source files
------------

// File: rtl/hid_cmd_sequencer.sv
// rtl/hid_cmd_sequencer.sv - decodes UART text lines into framebuffer pixel writes, cursor moves and status bytes
// Optional: define HID_CMD_ECHO_EN to follow the status byte with the latched opcode byte.
module hid_cmd_sequencer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int XW     = 6,
  parameter int YW     = 6,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_ready,
  input  logic [127:0]  line,
  output logic          busy,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic [CW-1:0] px_color,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PIXEL, S_CLEAR, S_RESP
`ifdef HID_CMD_ECHO_EN
    , S_ECHO
`endif
  } state_t;

  typedef enum logic [1:0] {A_ERR, A_PIXEL, A_CLEAR, A_MOVE} act_t;

  localparam logic [7:0] OP_P = 8'h50;
  localparam logic [7:0] OP_C = 8'h43;
  localparam logic [7:0] OP_M = 8'h4D;
  localparam logic [7:0] OP_D = 8'h44;

  state_t state, state_n;
  act_t   act;

  // Only bytes 0..5 can ever carry fields; the rest of the line is never looked at.
  logic [47:0] line_q;
  logic        unused_tail;
  assign unused_tail = ^line[127:48];

  function automatic logic [4:0] hex_digit(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
    return 5'b0;
  endfunction

  logic [4:0]    d1, d2, d3, d4, d5;
  logic [7:0]    fx, fy;
  logic          xy_ok;
  logic [XW-1:0] dec_x;
  logic [YW-1:0] dec_y;
  logic [3:0]    dec_c;
  logic          last_px;

  assign d1 = hex_digit(line_q[15:8]);
  assign d2 = hex_digit(line_q[23:16]);
  assign d3 = hex_digit(line_q[31:24]);
  assign d4 = hex_digit(line_q[39:32]);
  assign d5 = hex_digit(line_q[47:40]);
  assign fx = {d1[3:0], d2[3:0]};
  assign fy = {d3[3:0], d4[3:0]};
  assign xy_ok = d1[4] && d2[4] && d3[4] && d4[4] && (32'(fx) < WIDTH) && (32'(fy) < HEIGHT);
  assign last_px = (px_x == XW'(WIDTH - 1)) && (px_y == YW'(HEIGHT - 1));

  always_comb begin
    act   = A_ERR;
    dec_x = fx[XW-1:0];
    dec_y = fy[YW-1:0];
    dec_c = 4'd0;
    case (line_q[7:0])
      OP_P: if (xy_ok && d5[4] && (32'(d5[3:0]) < (1 << CW))) begin
        act   = A_PIXEL;
        dec_c = d5[3:0];
      end
      OP_C: if (d1[4] && (32'(d1[3:0]) < (1 << CW))) begin
        act   = A_CLEAR;
        dec_c = d1[3:0];
      end
      OP_M: if (xy_ok) act = A_MOVE;
      OP_D: if (d2[4] && (32'(d2[3:0]) < (1 << CW))) begin
        act   = A_PIXEL;
        dec_x = cur_x;
        dec_y = cur_y;
        dec_c = d2[3:0];
      end
      default: act = A_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    busy     = (state != S_IDLE);
    px_valid = 1'b0;
    tx_valid = 1'b0;
    case (state)
      S_IDLE:   if (line_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (act)
          A_PIXEL: state_n = S_PIXEL;
          A_CLEAR: state_n = S_CLEAR;
          default: state_n = S_RESP;
        endcase
      end
      S_PIXEL: begin
        px_valid = 1'b1;
        if (px_ready) state_n = S_RESP;
      end
      S_CLEAR: begin
        px_valid = 1'b1;
        if (px_ready && last_px) state_n = S_RESP;
      end
      S_RESP: begin
        tx_valid = 1'b1;
`ifdef HID_CMD_ECHO_EN
        if (tx_ready) state_n = S_ECHO;
`else
        if (tx_ready) state_n = S_IDLE;
`endif
      end
`ifdef HID_CMD_ECHO_EN
      S_ECHO: begin
        tx_valid = 1'b1;
        if (tx_ready) state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q   <= '0;
      px_x     <= '0;
      px_y     <= '0;
      px_color <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      tx_data  <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == S_IDLE && line_ready) line_q <= line[47:0];
      if (state != S_IDLE && line_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        S_DECODE: begin
          tx_data <= (act == A_ERR) ? 8'h45 : 8'h4B;
          case (act)
            A_PIXEL: begin
              px_x     <= dec_x;
              px_y     <= dec_y;
              px_color <= dec_c[CW-1:0];
            end
            A_CLEAR: begin
              px_x     <= '0;
              px_y     <= '0;
              px_color <= dec_c[CW-1:0];
            end
            A_MOVE: begin
              cur_x <= fx[XW-1:0];
              cur_y <= fy[YW-1:0];
            end
            default: ;
          endcase
        end
        // Raster scan, x fastest; the counters double as the write address.
        S_CLEAR: if (px_ready) begin
          if (px_x == XW'(WIDTH - 1)) begin
            px_x <= '0;
            px_y <= px_y + 1'b1;
          end else begin
            px_x <= px_x + 1'b1;
          end
        end
`ifdef HID_CMD_ECHO_EN
        S_RESP: if (tx_ready) tx_data <= line_q[7:0];
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hid_cmd_sequencer.sv
// tb/tb_hid_cmd_sequencer.sv - self-checking bench for hid_cmd_sequencer with a line-level reference model
module tb_hid_cmd_sequencer;
  localparam int W = 64;
  localparam int H = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line_ready = 1'b0;
  logic [127:0] line = '0;
  logic         busy, px_valid, tx_valid;
  logic         px_ready = 1'b0;
  logic         tx_ready = 1'b0;
  logic [5:0]   px_x, px_y, cur_x, cur_y;
  logic [3:0]   px_color;
  logic [7:0]   tx_data, drop_cnt;

  int checks = 0;
  int errors = 0;
  int mcx = 0, mcy = 0, mdrop = 0;
  int exp_px[$];
  int exp_tx[$];

  hid_cmd_sequencer #(.WIDTH(W), .HEIGHT(H), .XW(6), .YW(6), .CW(4)) dut (
    .clk(clk), .rst(rst), .line_ready(line_ready), .line(line), .busy(busy),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .cur_x(cur_x), .cur_y(cur_y), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] mk(input string s);
    logic [127:0] l = '0;
    for (int i = 0; i < s.len() && i < 16; i++) l[8*i +: 8] = s[i];
    return l;
  endfunction

  function automatic int hexv(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic int pk(input int x, input int y, input int c);
    return (x << 16) | (y << 8) | c;
  endfunction

  // Reference: interpret the command text directly and list the expected effects.
  task automatic model(input logic [127:0] l);
    int h[6];
    int x, y;
    bit ok = 0;
    for (int i = 0; i < 6; i++) h[i] = hexv(l[8*i +: 8]);
    x = h[1] * 16 + h[2];
    y = h[3] * 16 + h[4];
    case (l[7:0])
      8'h50: if (h[1] >= 0 && h[2] >= 0 && h[3] >= 0 && h[4] >= 0 && h[5] >= 0 && x < W && y < H) begin
        ok = 1;
        exp_px.push_back(pk(x, y, h[5]));
      end
      8'h43: if (h[1] >= 0) begin
        ok = 1;
        for (int i = 0; i < W * H; i++) exp_px.push_back(pk(i % W, i / W, h[1]));
      end
      8'h4D: if (h[1] >= 0 && h[2] >= 0 && h[3] >= 0 && h[4] >= 0 && x < W && y < H) begin
        ok = 1;
        mcx = x;
        mcy = y;
      end
      8'h44: if (h[2] >= 0) begin
        ok = 1;
        exp_px.push_back(pk(mcx, mcy, h[2]));
      end
      default: ok = 0;
    endcase
    exp_tx.push_back(ok ? 8'h4B : 8'h45);
`ifdef HID_CMD_ECHO_EN
    exp_tx.push_back(int'(l[7:0]));
`endif
  endtask

  function automatic logic [7:0] rand_hex();
    int r = $urandom_range(0, 31);
    if (r < 10) return 8'(48 + r);
    if (r < 16) return 8'(65 + r - 10);
    if (r < 22) return 8'(97 + r - 16);
    if (r < 29) return 8'(48 + r - 22);
    if (r == 29) return 8'h47;
    if (r == 30) return 8'h67;
    return 8'h3A;
  endfunction

  function automatic logic [127:0] gen_line();
    logic [127:0] l;
    int k = $urandom_range(0, 9);
    for (int i = 0; i < 16; i++) l[8*i +: 8] = 8'($urandom_range(32, 126));
    l[7:0] = (k < 3) ? 8'h50 : (k < 5) ? 8'h4D : (k < 7) ? 8'h44 : (k < 8) ? 8'h51 : 8'h70;
    for (int i = 1; i <= 5; i++) l[8*i +: 8] = rand_hex();
    if ($urandom_range(0, 3) != 0) l[15:8] = 8'(48 + $urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) l[31:24] = 8'(48 + $urandom_range(0, 3));
    return l;
  endfunction

  task automatic drive(input int mode, input int cyc);
    if (mode == 0) begin
      px_ready = 1'b1; tx_ready = 1'b1;
    end else if (mode == 1) begin
      px_ready = (cyc % 2 == 0); tx_ready = (cyc % 2 == 0);
    end else begin
      px_ready = 1'($urandom_range(0, 1)); tx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_cmd(input logic [127:0] l, input int mode, input int ninj);
    int cyc = 0;
    bit pv_hold = 0, tv_hold = 0;
    int pv_prev = 0, tv_prev = 0;
    model(l);
    @(negedge clk);
    line = l; line_ready = 1'b1; drive(mode, 0);
    forever begin
      @(negedge clk);
      line_ready = 1'b0;
      drive(mode, cyc);
      #1;
      if (pv_hold) chk("px_hold", px_valid ? pk(px_x, px_y, px_color) : -1, pv_prev);
      if (tv_hold) chk("tx_hold", tx_valid ? int'(tx_data) : -1, tv_prev);
      if (px_valid && px_ready) begin
        if (exp_px.size() == 0) chk("px_extra", pk(px_x, px_y, px_color), 32'hFFFF_FFFF);
        else chk("px_write", pk(px_x, px_y, px_color), exp_px.pop_front());
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) chk("tx_extra", tx_data, 32'hFFFF_FFFF);
        else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      pv_hold = px_valid && !px_ready; pv_prev = pk(px_x, px_y, px_color);
      tv_hold = tx_valid && !tx_ready; tv_prev = int'(tx_data);
      if (!busy) break;
      if (ninj > 0 && cyc % 100 == 99) begin
        line_ready = 1'b1;
        line = {$urandom, $urandom, $urandom, $urandom};
        ninj--;
        if (mdrop < 255) mdrop++;
      end
      cyc++;
      if (cyc > 20000) begin
        chk("timeout", 1, 0);
        break;
      end
    end
    line_ready = 1'b0;
    chk("px_left", exp_px.size(), 0);
    chk("tx_left", exp_tx.size(), 0);
    chk("cur_x", cur_x, mcx);
    chk("cur_y", cur_y, mcy);
    chk("drop_cnt", drop_cnt, mdrop);
    exp_px.delete();
    exp_tx.delete();
  endtask

  initial begin
    int seen;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_px_valid", px_valid, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_px", {px_x, px_y, px_color}, 0);
    chk("rst_cur", {cur_x, cur_y}, 0);
    chk("rst_tx_drop", {tx_data, drop_cnt}, 0);
    @(negedge clk); rst = 1'b0;

    // P timing: px_valid first at n+2, then 'K', cursor untouched.
    @(negedge clk);
    line = mk("P0A1F7"); line_ready = 1'b1; px_ready = 1'b1; tx_ready = 1'b1;
    @(negedge clk); line_ready = 1'b0; #1;
    chk("p_n1_busy", busy, 1);
    chk("p_n1_px_valid", px_valid, 0);
    @(negedge clk); #1;
    chk("p_n2_px_valid", px_valid, 1);
    chk("p_n2_px", pk(px_x, px_y, px_color), pk(10, 31, 7));
    @(negedge clk); #1;
    chk("p_px_done", px_valid, 0);
    chk("p_tx_valid", tx_valid, 1);
    chk("p_tx_data", tx_data, 8'h4B);
`ifdef HID_CMD_ECHO_EN
    @(negedge clk); #1;
    chk("p_echo", tx_data, 8'h50);
`endif
    @(negedge clk); #1;
    chk("p_idle", busy, 0);
    chk("p_cur", {cur_x, cur_y}, 0);

    run_cmd(mk("C3"), 1, 0);

    // M timing: cursor and tx_valid both visible at n+2.
    @(negedge clk);
    line = mk("M0504"); line_ready = 1'b1; tx_ready = 1'b1;
    @(negedge clk); line_ready = 1'b0; #1;
    chk("m_n1_tx_valid", tx_valid, 0);
    @(negedge clk); #1;
    chk("m_n2_tx_valid", tx_valid, 1);
    chk("m_n2_tx_data", tx_data, 8'h4B);
    chk("m_n2_cur", {cur_x, cur_y}, {6'd5, 6'd4});
    chk("m_no_px", px_valid, 0);
    seen = 0;
    while (busy && seen < 10) begin @(negedge clk); #1; seen++; end
    chk("m_idle", busy, 0);
    mcx = 5; mcy = 4;
    run_cmd(mk("D 9"), 0, 0);

    run_cmd(mk("P4000A1"), 2, 0);
    run_cmd(mk("PZZ001"), 2, 0);
    run_cmd(mk("Q"), 2, 0);
    run_cmd(mk("c7"), 2, 0);
    run_cmd(mk("Mf0A0"), 2, 0);

    for (int i = 0; i < 30; i++) run_cmd(gen_line(), 2, 0);

    run_cmd(mk("C5"), 0, 3);

`ifdef HID_CMD_ECHO_EN
    @(negedge clk);
    line = mk("M0102"); line_ready = 1'b1; tx_ready = 1'b0;
    @(negedge clk); line_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("echo_hold_valid", tx_valid, 1);
      chk("echo_hold_status", tx_data, 8'h4B);
    end
    @(negedge clk); tx_ready = 1'b1; #1;
    chk("echo_status", tx_data, 8'h4B);
    @(negedge clk); #1;
    chk("echo_op_valid", tx_valid, 1);
    chk("echo_op", tx_data, 8'h4D);
    chk("echo_busy", busy, 1);
    @(negedge clk); #1;
    chk("echo_idle", busy, 0);
    mcx = 1; mcy = 2;
`endif

    // Reset in the middle of a clear aborts it with no completion byte.
    @(negedge clk);
    line = mk("C2"); line_ready = 1'b1; px_ready = 1'b1; tx_ready = 1'b1;
    @(negedge clk); line_ready = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst = 1'b1; #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_px_valid", px_valid, 0);
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_px", {px_x, px_y, px_color}, 0);
    chk("mrst_cur", {cur_x, cur_y}, 0);
    chk("mrst_tx_drop", {tx_data, drop_cnt}, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); #1; if (tx_valid || px_valid) seen++; end
    chk("no_resp_after_rst", seen, 0);
    mcx = 0; mcy = 0; mdrop = 0;
    run_cmd(mk("P3F3Fa"), 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
